mem_arbiter_rr: RTL and testbench
=================================

# mem_arbiter_rr

Parametrised N-port memory arbiter between the cache/prefetch requesters and the single cacheline adapter. It generalises the fixed four-client icache/dcache/prefetch arbiter to NUM_PORTS clients with selectable fixed-priority or round-robin arbitration. It latches the winner's command, address and write data at grant, so the memory side is unaffected by requester-side changes mid-transaction. Port 0 is the icache, port 1 the dcache, and higher ports are prefetchers.

## Interface
- NUM_PORTS, 4: number of requesters (2..8).
- ADDR_W, 32: address width.
- LINE_W, 256: cacheline width.
- RR_MODE, 1: 0 = fixed priority (lowest index wins); 1 = round-robin.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_read  in  NUM_PORTS  per-port read request; held until that port's req_resp.
- req_write  in  NUM_PORTS  per-port write request; held until req_resp.
- req_addr  in  NUM_PORTS*ADDR_W  per-port address; port i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_PORTS*LINE_W  per-port write line.
- req_resp  out  NUM_PORTS  one-hot completion pulse.
- req_rdata  out  LINE_W  read line, shared by all ports; valid only with req_resp.
- mem_read  out  1  read command to adapter.
- mem_write  out  1  write command to adapter.
- mem_address  out  ADDR_W  latched address.
- mem_wdata  out  LINE_W  latched write data.
- mem_rdata  in  LINE_W  adapter read data.
- mem_resp  in  1  adapter completion.

## Operation
- States: IDLE, BUSY, DONE.
- Port i is active when req_read[i] | req_write[i].
- IDLE:
  - If any port is active, select winner g and register grant=g, op (write if req_write[g], else read), addr and wdata. Go to BUSY.
  - If no port is active, stay in IDLE.
- Simultaneous read and write on the same port: write wins. The bench flags this as an assertion warning.
- Fixed mode: the lowest active index wins.
- Round-robin mode: the first active index at or after ptr wins, wrapping modulo NUM_PORTS.
- BUSY:
  - mem_read = (op == read); mem_write = (op == write).
  - mem_address and mem_wdata come from registers.
  - req_resp[grant] = mem_resp; req_rdata = mem_rdata. Both are combinational pass-throughs.
  - On mem_resp: go to DONE. In round-robin mode, ptr <= (grant+1) mod NUM_PORTS.
- DONE: one dead cycle with all commands low, so the served port can drop its request. Then go to IDLE.
- Deasserting a request during BUSY is illegal. The transaction still completes with the latched values.

## Timing
- Reset values:
  - State IDLE, ptr 0, grant 0, op read.
  - Latched addr and wdata are 0.
  - All outputs 0: mem_read, mem_write, req_resp, req_rdata = 0; mem_address and mem_wdata = 0.
- Request seen in cycle t (IDLE) → mem_read/mem_write high from t+1.
- mem_resp in cycle u → req_resp in cycle u (same cycle). Command low at u+1 (DONE). The next grant decision is at u+2; the next command is at u+3.
- Minimum back-to-back spacing is 3 cycles plus the memory latency.
- req_rdata is 0 when req_resp is low.
- mem_wdata holds its latched value in all states. It is only meaningful while mem_write is high.
- Reset asserted mid-BUSY: the arbiter returns to IDLE next cycle and drops the command. The adapter is reset alongside it.
- NUM_PORTS not a power of two: the ptr wrap is an explicit compare-to-NUM_PORTS-1, not a bit truncation.

## Structure
- Package arb_pkg holds:
  - arb_state_e {IDLE, BUSY, DONE}.
  - arb_op_e {OP_READ, OP_WRITE}.
  - Function clog2_min1 for grant/ptr width: max(1, $clog2(NUM_PORTS)).
- Sub-module rr_select, purely combinational:
  - Inputs: active[NUM_PORTS], ptr, rr_mode.
  - Outputs: valid, winner index.
  - Implemented as a double-width masked priority encoder.
- The top module holds the FSM, the latches and the response demux.

## Test plan
- Single read, fixed mode: port 1 reads 0x0000_1040; mem_resp after 5 cycles with rdata 0xA5…A5. Required:
  - mem_read rises 1 cycle after the request.
  - mem_address = 0x0000_1040.
  - req_resp = 4'b0010 for exactly 1 cycle, with req_rdata = 0xA5…A5.
- Fixed priority: ports 0, 2 and 3 request together; each is held until served. Required service order is 0, 2, 3.
- Round-robin fairness: all 4 ports continuously active for 8 grants, 2-cycle memory. Required grant order is 0,1,2,3,0,1,2,3.
- Write latch: port 3 writes wdata 0xDEAD…BEEF to 0x2000. The requester changes req_addr to 0x3000 during BUSY. Required:
  - mem_write is set.
  - mem_address stays 0x2000 and mem_wdata is unchanged until mem_resp.
- Reset mid-transaction: rst during BUSY. Required next cycle: mem_read = 0, state IDLE, ptr 0.
- NUM_PORTS=3, round-robin: ports 2 and 0 both active with ptr=2. Required order is 2 then 0; ptr wraps to 0 after port 2 is served.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the N-port memory arbiter.
package arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_e;
    typedef enum logic       {OP_READ, OP_WRITE} arb_op_e;

    // Index width for grant/ptr, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_select.sv
// Winner selection: fixed priority or round-robin from ptr, as a
// double-width masked priority encoder so the wrap needs no modulo logic.
module rr_select #(
    parameter int NUM_PORTS = 4,
    parameter int PW        = 2
) (
    input  logic [NUM_PORTS-1:0] active,
    input  logic [PW-1:0]        ptr,
    input  logic                 rr_mode,
    output logic                 valid,
    output logic [PW-1:0]        winner
);

    logic [2*NUM_PORTS-1:0] dbl;

    always_comb begin
        dbl = {active, active};
        // Lower copy only holds ports at or after ptr; upper copy covers the wrap.
        for (int j = 0; j < NUM_PORTS; j++)
            if (rr_mode && (j < int'(ptr))) dbl[j] = 1'b0;
        valid  = 1'b0;
        winner = '0;
        for (int j = 2*NUM_PORTS-1; j >= 0; j--) begin
            if (dbl[j]) begin
                valid  = 1'b1;
                winner = (j >= NUM_PORTS) ? PW'(j - NUM_PORTS) : PW'(j);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-port arbiter in front of the cacheline adapter; latches the winner's
// command at grant so requester-side changes cannot disturb the memory side.
module mem_arbiter_rr
    import arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 32,
    parameter int LINE_W    = 256,
    parameter int RR_MODE   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req_read,
    input  logic [NUM_PORTS-1:0]        req_write,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*LINE_W-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]        req_resp,
    output logic [LINE_W-1:0]           req_rdata,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic [ADDR_W-1:0]           mem_address,
    output logic [LINE_W-1:0]           mem_wdata,
    input  logic [LINE_W-1:0]           mem_rdata,
    input  logic                        mem_resp
);

    localparam int PW = clog2_min1(NUM_PORTS);

    arb_state_e          state;
    arb_op_e             op;
    logic [PW-1:0]       ptr, grant, winner;
    logic                win_valid, sel_wr;
    logic [ADDR_W-1:0]   addr_q, sel_addr;
    logic [LINE_W-1:0]   wdata_q, sel_wdata;

    rr_select #(.NUM_PORTS(NUM_PORTS), .PW(PW)) u_sel (
        .active  (req_read | req_write),
        .ptr     (ptr),
        .rr_mode (RR_MODE != 0),
        .valid   (win_valid),
        .winner  (winner)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wr    = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (winner == PW'(i)) begin
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*LINE_W +: LINE_W];
                sel_wr    = req_write[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            grant   <= '0;
            op      <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: if (win_valid) begin
                    grant   <= winner;
                    op      <= sel_wr ? OP_WRITE : OP_READ;
                    addr_q  <= sel_addr;
                    wdata_q <= sel_wdata;
                    state   <= BUSY;
                end
                BUSY: if (mem_resp) begin
                    state <= DONE;
                    // Explicit wrap so non-power-of-two port counts stay in range.
                    if (RR_MODE != 0)
                        ptr <= (grant == PW'(NUM_PORTS-1)) ? '0 : grant + PW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_read    = (state == BUSY) && (op == OP_READ);
    assign mem_write   = (state == BUSY) && (op == OP_WRITE);
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign req_rdata   = ((state == BUSY) && mem_resp) ? mem_rdata : '0;

    always_comb begin
        req_resp = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            if ((state == BUSY) && mem_resp && (grant == PW'(i))) req_resp[i] = 1'b1;
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench: fixed-priority vector table plus round-robin and 3-port sequences.
module tb_mem_arbiter_rr;
    import arb_pkg::*;

    localparam logic [255:0] A5   = {32{8'hA5}};
    localparam logic [255:0] DB   = {8{32'hDEADBEEF}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // fixed-priority 4-port instance
    logic [3:0]    f_rd = '0, f_wr = '0, f_resp_o;
    logic [127:0]  f_addr = {32'h300, 32'h200, 32'h1040, 32'h100};
    logic [1023:0] f_wdata = {4{ {8{32'h0BADF00D}} }};
    logic [255:0]  f_rdata_o, f_mwdata;
    logic          f_mrd, f_mwr, f_mresp = 1'b0;
    logic [31:0]   f_maddr;

    // round-robin 4-port instance
    logic [3:0]    r_rd = '0, r_wr = '0, r_resp_o;
    logic [127:0]  r_addr = '0;
    logic [1023:0] r_wdata = '0;
    logic [255:0]  r_rdata_o, r_mwdata;
    logic          r_mrd, r_mwr, r_mresp = 1'b0;
    logic [31:0]   r_maddr;

    // round-robin 3-port instance
    logic [2:0]    t_rd = '0, t_wr = '0, t_resp_o;
    logic [95:0]   t_addr = '0;
    logic [767:0]  t_wdata = '0;
    logic [255:0]  t_rdata_o, t_mwdata;
    logic          t_mrd, t_mwr, t_mresp = 1'b0;
    logic [31:0]   t_maddr;

    mem_arbiter_rr #(.NUM_PORTS(4), .RR_MODE(0)) dut_fx (
        .clk(clk), .rst(rst), .req_read(f_rd), .req_write(f_wr), .req_addr(f_addr),
        .req_wdata(f_wdata), .req_resp(f_resp_o), .req_rdata(f_rdata_o),
        .mem_read(f_mrd), .mem_write(f_mwr), .mem_address(f_maddr), .mem_wdata(f_mwdata),
        .mem_rdata(A5), .mem_resp(f_mresp));

    mem_arbiter_rr #(.NUM_PORTS(4), .RR_MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .req_read(r_rd), .req_write(r_wr), .req_addr(r_addr),
        .req_wdata(r_wdata), .req_resp(r_resp_o), .req_rdata(r_rdata_o),
        .mem_read(r_mrd), .mem_write(r_mwr), .mem_address(r_maddr), .mem_wdata(r_mwdata),
        .mem_rdata(A5), .mem_resp(r_mresp));

    mem_arbiter_rr #(.NUM_PORTS(3), .RR_MODE(1)) dut3 (
        .clk(clk), .rst(rst), .req_read(t_rd), .req_write(t_wr), .req_addr(t_addr),
        .req_wdata(t_wdata), .req_resp(t_resp_o), .req_rdata(t_rdata_o),
        .mem_read(t_mrd), .mem_write(t_mwr), .mem_address(t_maddr), .mem_wdata(t_mwdata),
        .mem_rdata(A5), .mem_resp(t_mresp));

    always @(posedge clk)
        if (!rst && ((f_rd & f_wr) != 4'b0))
            $warning("simultaneous read and write requested on fixed-mode port(s) %b", f_rd & f_wr);

    typedef struct {
        logic [3:0]  rd, wr;
        logic        resp;
        logic        e_rd, e_wr;
        logic [3:0]  e_resp;
        logic [31:0] e_addr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [3:0] rd, logic [3:0] wr, logic resp,
                                logic erd, logic ewr, logic [3:0] eresp, logic [31:0] eaddr);
        vec_t v;
        v.rd = rd; v.wr = wr; v.resp = resp;
        v.e_rd = erd; v.e_wr = ewr; v.e_resp = eresp; v.e_addr = eaddr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timed out waiting for memory command", nm);
    endtask

    // Wait for the 4-port rr command, answer after lat busy cycles, check the grant.
    task automatic rr_serve(input logic [3:0] exp, input int lat, input string nm);
        int n = 0;
        while (!(r_mrd | r_mwr) && n < 20) begin @(negedge clk); #1; n++; end
        if (n >= 20) timeout(nm);
        else begin
            repeat (lat-1) @(negedge clk);
            r_mresp = 1'b1; #1;
            chk(nm, 256'(r_resp_o), 256'(exp));
            @(negedge clk);
            r_mresp = 1'b0;
        end
    endtask

    task automatic t_serve(input logic [2:0] exp, input string nm);
        int n = 0;
        while (!(t_mrd | t_mwr) && n < 20) begin @(negedge clk); #1; n++; end
        if (n >= 20) timeout(nm);
        else begin
            t_mresp = 1'b1; #1;
            chk(nm, 256'(t_resp_o), 256'(exp));
            @(negedge clk);
            t_mresp = 1'b0;
        end
    endtask

    logic [3:0] rr_order [8];

    initial begin
        // single read on port 1, then fixed priority 0,2,3, then read+write on port 0
        tbl.push_back(mk(4'b0010, 4'b0000, 0, 0, 0, 4'b0000, 32'h0));
        tbl.push_back(mk(4'b0010, 4'b0000, 0, 1, 0, 4'b0000, 32'h1040));
        tbl.push_back(mk(4'b0010, 4'b0000, 0, 1, 0, 4'b0000, 32'h1040));
        tbl.push_back(mk(4'b0010, 4'b0000, 0, 1, 0, 4'b0000, 32'h1040));
        tbl.push_back(mk(4'b0010, 4'b0000, 0, 1, 0, 4'b0000, 32'h1040));
        tbl.push_back(mk(4'b0010, 4'b0000, 1, 1, 0, 4'b0010, 32'h1040));
        tbl.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 32'h1040));
        tbl.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 32'h1040));
        tbl.push_back(mk(4'b1101, 4'b0000, 0, 0, 0, 4'b0000, 32'h1040));
        tbl.push_back(mk(4'b1101, 4'b0000, 1, 1, 0, 4'b0001, 32'h100));
        tbl.push_back(mk(4'b1100, 4'b0000, 0, 0, 0, 4'b0000, 32'h100));
        tbl.push_back(mk(4'b1100, 4'b0000, 0, 0, 0, 4'b0000, 32'h100));
        tbl.push_back(mk(4'b1100, 4'b0000, 1, 1, 0, 4'b0100, 32'h200));
        tbl.push_back(mk(4'b1000, 4'b0000, 0, 0, 0, 4'b0000, 32'h200));
        tbl.push_back(mk(4'b1000, 4'b0000, 0, 0, 0, 4'b0000, 32'h200));
        tbl.push_back(mk(4'b1000, 4'b0000, 1, 1, 0, 4'b1000, 32'h300));
        tbl.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 32'h300));
        tbl.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 32'h300));
        tbl.push_back(mk(4'b0001, 4'b0001, 0, 0, 0, 4'b0000, 32'h300));
        tbl.push_back(mk(4'b0001, 4'b0001, 0, 0, 1, 4'b0000, 32'h100));
        tbl.push_back(mk(4'b0001, 4'b0001, 1, 0, 1, 4'b0001, 32'h100));
        tbl.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 32'h100));
        rr_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_read",  256'(f_mrd), 256'(0));
        chk("rst_mem_write", 256'(f_mwr), 256'(0));
        chk("rst_req_resp",  256'(f_resp_o), 256'(0));
        chk("rst_req_rdata", f_rdata_o, 256'(0));
        chk("rst_mem_addr",  256'(f_maddr), 256'(0));
        chk("rst_mem_wdata", f_mwdata, 256'(0));
        chk("rst_state",     256'(dut_rr.state), 256'(IDLE));
        chk("rst_ptr",       256'(dut_rr.ptr), 256'(0));
        @(negedge clk);
        rst = 1'b0;

        // fixed-priority vector table, one row per cycle
        foreach (tbl[k]) begin
            f_rd = tbl[k].rd; f_wr = tbl[k].wr; f_mresp = tbl[k].resp;
            #1;
            chk($sformatf("vec%0d_mem_read", k),  256'(f_mrd), 256'(tbl[k].e_rd));
            chk($sformatf("vec%0d_mem_write", k), 256'(f_mwr), 256'(tbl[k].e_wr));
            chk($sformatf("vec%0d_req_resp", k),  256'(f_resp_o), 256'(tbl[k].e_resp));
            chk($sformatf("vec%0d_mem_addr", k),  256'(f_maddr), 256'(tbl[k].e_addr));
            chk($sformatf("vec%0d_req_rdata", k), f_rdata_o, (tbl[k].e_resp != 4'b0) ? A5 : 256'(0));
            @(negedge clk);
        end
        f_mresp = 1'b0;

        // round-robin fairness: all ports held, 2-cycle memory
        r_rd = 4'b1111;
        for (int g = 0; g < 8; g++) rr_serve(rr_order[g], 2, $sformatf("rr_grant%0d", g));
        r_rd = 4'b0000;
        #1;
        chk("rr_ptr_after_fair", 256'(dut_rr.ptr), 256'(0));

        // write latch: requester changes address/data mid-transaction
        r_wr = 4'b1000;
        r_addr[96 +: 32] = 32'h2000;
        r_wdata[768 +: 256] = DB;
        begin
            int n = 0;
            while (!(r_mrd | r_mwr) && n < 20) begin @(negedge clk); #1; n++; end
            if (n >= 20) timeout("wr_wait");
        end
        chk("wr_mem_write", 256'(r_mwr), 256'(1));
        chk("wr_mem_read",  256'(r_mrd), 256'(0));
        chk("wr_addr0",     256'(r_maddr), 256'(32'h2000));
        chk("wr_wdata0",    r_mwdata, DB);
        chk("wr_rdata_idle", r_rdata_o, 256'(0));
        r_addr[96 +: 32] = 32'h3000;
        r_wdata[768 +: 256] = '0;
        @(negedge clk); #1;
        chk("wr_addr1",  256'(r_maddr), 256'(32'h2000));
        chk("wr_wdata1", r_mwdata, DB);
        r_mresp = 1'b1; #1;
        chk("wr_resp",  256'(r_resp_o), 256'(4'b1000));
        chk("wr_addr2", 256'(r_maddr), 256'(32'h2000));
        @(negedge clk);
        r_mresp = 1'b0; r_wr = 4'b0000;

        // port 1 read moves ptr to 2, then reset during port 2's BUSY
        r_rd = 4'b0010;
        rr_serve(4'b0010, 1, "rr_p1");
        r_rd = 4'b0000;
        #1;
        chk("rr_ptr_2", 256'(dut_rr.ptr), 256'(2));
        r_rd = 4'b0100;
        begin
            int n = 0;
            while (!(r_mrd | r_mwr) && n < 20) begin @(negedge clk); #1; n++; end
            if (n >= 20) timeout("rst_wait");
        end
        chk("rstb_mem_read", 256'(r_mrd), 256'(1));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("rstb_mem_read_low", 256'(r_mrd), 256'(0));
        chk("rstb_state",        256'(dut_rr.state), 256'(IDLE));
        chk("rstb_ptr",          256'(dut_rr.ptr), 256'(0));
        rst = 1'b0; r_rd = 4'b0000;
        @(negedge clk);

        // 3-port round robin: get ptr to 2, then ports 2 and 0 together
        t_rd = 3'b010;
        t_serve(3'b010, "p3_p1");
        t_rd = 3'b000;
        #1;
        chk("p3_ptr_2", 256'(dut3.ptr), 256'(2));
        t_rd = 3'b101;
        t_serve(3'b100, "p3_first_2");
        t_rd = 3'b001;
        #1;
        chk("p3_ptr_wrap", 256'(dut3.ptr), 256'(0));
        t_serve(3'b001, "p3_then_0");
        t_rd = 3'b000;
        #1;
        chk("p3_ptr_1", 256'(dut3.ptr), 256'(1));

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

endmodule
